stim_gen_param: RTL and testbench
=================================

Name: stim_gen_param

Overview:
- Synthesisable, parametrised stimulus source for the pattern-recognition detectors; it replaces free-running random-bit benches.
- Emits a DATA_W-bit word per handshake in one of three modes: Galois-LFSR random, repeating loaded pattern, or incrementing counter.
- Supports a bounded run length and a valid/ready output handshake.
- Feeds the detector input (inp) in both simulation and FPGA self-test.

Parameters:
- DATA_W, 1, bits emitted per beat (1 = serial detector input).
- LFSR_W, 16, LFSR state width; must be >= DATA_W.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- PAT_LEN, 8, pattern register length; must be a multiple of DATA_W.
- CNT_W, 16, width of the run-length and beat counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- mode  in  2  00 LFSR, 01 pattern, 10 counter, 11 treated as LFSR.
- seed  in  LFSR_W  LFSR seed, sampled at start.
- pattern  in  PAT_LEN  pattern, sampled at start; LSB emitted first.
- num_beats  in  CNT_W  beats to emit; 0 = free-run; sampled at start.
- ready  in  1  consumer accepts the word.
- inp  out  DATA_W  stimulus word.
- valid  out  1  inp is meaningful.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of a bounded run.
- beat_count  out  CNT_W  beats accepted in the current or last run.

Behaviour:
- Reset (async assert, sync release): state IDLE; inp=0, valid=0, busy=0, done=0, beat_count=0; LFSR, pattern and counter registers all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mode, seed, pattern and num_beats; clears beat_count and the counter register; goes to RUN.
  - A seed of 0 is replaced by 1, so the LFSR never locks up.
  - valid rises the cycle after start (latency 1), and the first word is presented in that same cycle.
- RUN, word presented:
  - LFSR mode: lfsr[DATA_W-1:0].
  - Pattern mode: pat_reg[DATA_W-1:0].
  - Counter mode: cnt_reg[DATA_W-1:0].
- RUN, on a handshake (valid & ready):
  - beat_count increments.
  - The LFSR advances DATA_W Galois steps; one step is: lsb set -> (s>>1)^TAPS, else s>>1.
  - pat_reg rotates right by DATA_W.
  - cnt_reg increments modulo 2^DATA_W.
- ready=0 holds inp and valid stable; no state advances.
- Bounded run:
  - If num_beats != 0 and the handshake makes beat_count == num_beats, go to DONE.
  - valid drops in the next cycle.
  - beat_count holds its final value until the next start.
- Free-run (num_beats=0): stays in RUN indefinitely; beat_count wraps modulo 2^CNT_W with no effect on the run.
- DONE: done=1 for exactly one cycle, valid=0, busy=0, then IDLE.
- start is ignored in RUN and DONE.
- A start asserted in the same cycle as DONE is lost and must be reasserted.
- reset mid-run aborts immediately with no done pulse.
- Widths: all counters are unsigned and wrap.

Optional Feature:
- Macro: STIM_INJECT_EN.
- With the macro, LFSR mode gains a parameter INJ_PERIOD (default 64) and an output port inj_active (1 bit):
  - Every INJ_PERIOD accepted beats, the block emits the latched pattern in full (PAT_LEN/DATA_W beats) instead of LFSR words.
  - The LFSR is frozen during injection, and inj_active=1 for those beats.
  - Injected beats count toward num_beats.
  - Injection guarantees the detector sees at least one hit per period.
- Without the macro: no inj_active port and no injection logic; LFSR mode is pure random.

Decomposition:
- Shared package stim_pkg:
  - mode encodings MODE_LFSR, MODE_PAT, MODE_CNT;
  - FSM state typedef (IDLE/RUN/DONE);
  - default TAPS constant.
- One sub-module, lfsr_step_n (LFSR_W, TAPS, STEPS), combinationally computes STEPS Galois steps.
- The FSM, pattern rotation and counters stay in the top module.

Test Plan:
- LFSR, DATA_W=1, seed=16'h0001, num_beats=3, ready=1 -> inp 1,0,0 with LFSR states 0001, B400, 5A00; done pulses one cycle after the third beat; beat_count=3.
- Pattern, pattern=8'b10110010, num_beats=16 -> inp 0,1,0,0,1,1,0,1 repeated twice; done asserted; busy low afterwards.
- Counter, DATA_W=4, num_beats=18 -> inp 0..F, 0, 1 (wrap); beat_count=18.
- Backpressure: ready toggled 1,0,0,1 in pattern mode -> inp held stable over the stalls; beat_count advances only on ready=1 cycles.
- seed=0 -> behaves exactly as seed=1; reset asserted mid-run at beat 5 -> outputs zero immediately, no done pulse; start accepted again after release.
- With STIM_INJECT_EN, INJ_PERIOD=4, PAT_LEN=8 -> after 4 LFSR beats, 8 pattern bits are emitted with inj_active=1, then LFSR resumes from its frozen state.

Source files
------------

// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared encodings for the stimulus generator
// Purpose: mode encodings, FSM state type and default Galois feedback mask
//          shared by stim_gen_param and its bench.
package stim_pkg;

  localparam logic [1:0] MODE_LFSR = 2'b00;
  localparam logic [1:0] MODE_PAT  = 2'b01;
  localparam logic [1:0] MODE_CNT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr_step_n.sv
// rtl/lfsr_step_n.sv - combinational STEPS-fold Galois LFSR advance
// Purpose: computes the LFSR state after STEPS right-shifting Galois steps.
// Ports:
//   state_i  in  LFSR_W  current LFSR state
//   state_o  out LFSR_W  state after STEPS steps
module lfsr_step_n #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter int                STEPS  = 1
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s = state_i;
    for (int i = 0; i < STEPS; i++) begin
      s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    end
    state_o = s;
  end

endmodule

// File: rtl/stim_gen_param.sv
// rtl/stim_gen_param.sv - parametrised stimulus source (LFSR / pattern / counter)
// Purpose: emits one DATA_W-bit word per valid/ready handshake, either from a
//          Galois LFSR, a rotating loaded pattern or an incrementing counter,
//          for a bounded (num_beats) or free-running run.
// Ports:
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous active-high reset
//   start       in   1       begin a run (sampled in IDLE only)
//   mode        in   2       00 LFSR, 01 pattern, 10 counter, 11 LFSR
//   seed        in   LFSR_W  LFSR seed (0 is replaced by 1)
//   pattern     in   PAT_LEN pattern, LSB emitted first
//   num_beats   in   CNT_W   beats to emit, 0 = free-run
//   ready       in   1       consumer accepts inp
//   inp         out  DATA_W  stimulus word
//   valid       out  1       inp is meaningful
//   busy        out  1       run in progress
//   done        out  1       one-cycle pulse at end of a bounded run
//   beat_count  out  CNT_W   beats accepted in current/last run
//   inj_active  out  1       (STIM_INJECT_EN only) current word is injected pattern
// Optional feature macro: STIM_INJECT_EN (adds parameter INJ_PERIOD and port
//   inj_active; LFSR mode then injects the full pattern every INJ_PERIOD
//   LFSR beats while the LFSR is frozen).
module stim_gen_param
  import stim_pkg::*;
#(
  parameter int                DATA_W  = 1,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(DEFAULT_TAPS),
  parameter int                PAT_LEN = 8,
  parameter int                CNT_W   = 16
`ifdef STIM_INJECT_EN
  , parameter int              INJ_PERIOD = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [LFSR_W-1:0]  seed,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [CNT_W-1:0]   num_beats,
  input  logic               ready,
  output logic [DATA_W-1:0]  inp,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   beat_count
`ifdef STIM_INJECT_EN
  , output logic             inj_active
`endif
);

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d, lfsr_adv, seed_fix;
  logic [PAT_LEN-1:0] pat_q, pat_d, pat_rot;
  logic [DATA_W-1:0]  cnt_q, cnt_d, inp_q, word_d, start_word;
  logic [CNT_W-1:0]   num_q, beat_q, beat_inc;
  logic               valid_q, busy_q, done_q;
  logic [1:0]         mode_norm;
  logic               handshake, last_beat;

`ifdef STIM_INJECT_EN
  localparam logic [CNT_W-1:0] INJ_LAST  = CNT_W'(INJ_PERIOD - 1);
  localparam logic [CNT_W-1:0] PAT_BEATS = CNT_W'(PAT_LEN / DATA_W);
  logic             inj_q, inj_d;
  logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d, inj_left_q, inj_left_d;
`endif

  lfsr_step_n #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .STEPS  (DATA_W)
  ) u_lfsr_step (
    .state_i (lfsr_q),
    .state_o (lfsr_adv)
  );

  assign pat_rot   = (pat_q >> DATA_W) | (pat_q << (PAT_LEN - DATA_W));
  assign seed_fix  = (seed == '0) ? LFSR_W'(1) : seed;
  assign mode_norm = (mode == MODE_PAT || mode == MODE_CNT) ? mode : MODE_LFSR;
  assign handshake = valid_q & ready;
  assign beat_inc  = beat_q + CNT_W'(1);
  assign last_beat = (num_q != '0) && (beat_inc == num_q);

  // First word is presented the cycle after start, from the freshly latched state.
  always_comb begin
    case (mode_norm)
      MODE_PAT: start_word = pattern[DATA_W-1:0];
      MODE_CNT: start_word = '0;
      default:  start_word = seed_fix[DATA_W-1:0];
    endcase
  end

  // Next datapath state and next presented word, applied only on a handshake.
  always_comb begin
    lfsr_d = lfsr_q;
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    word_d = inp_q;
`ifdef STIM_INJECT_EN
    inj_d      = inj_q;
    inj_cnt_d  = inj_cnt_q;
    inj_left_d = inj_left_q;
`endif
    case (mode_q)
      MODE_PAT: begin
        pat_d  = pat_rot;
        word_d = pat_rot[DATA_W-1:0];
      end
      MODE_CNT: begin
        cnt_d  = cnt_q + DATA_W'(1);
        word_d = cnt_d;
      end
      default: begin
`ifdef STIM_INJECT_EN
        if (inj_q) begin
          // Injection rotates the pattern a full turn, so it ends where it began.
          pat_d = pat_rot;
          if (inj_left_q == CNT_W'(1)) begin
            inj_d  = 1'b0;
            word_d = lfsr_q[DATA_W-1:0];
          end else begin
            inj_left_d = inj_left_q - CNT_W'(1);
            word_d     = pat_rot[DATA_W-1:0];
          end
        end else if (inj_cnt_q == INJ_LAST) begin
          lfsr_d     = lfsr_adv;
          inj_d      = 1'b1;
          inj_left_d = PAT_BEATS;
          inj_cnt_d  = '0;
          word_d     = pat_q[DATA_W-1:0];
        end else begin
          lfsr_d    = lfsr_adv;
          inj_cnt_d = inj_cnt_q + CNT_W'(1);
          word_d    = lfsr_adv[DATA_W-1:0];
        end
`else
        lfsr_d = lfsr_adv;
        word_d = lfsr_adv[DATA_W-1:0];
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_LFSR;
      lfsr_q  <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      beat_q  <= '0;
      inp_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STIM_INJECT_EN
      inj_q      <= 1'b0;
      inj_cnt_q  <= '0;
      inj_left_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode_norm;
            lfsr_q  <= seed_fix;
            pat_q   <= pattern;
            cnt_q   <= '0;
            num_q   <= num_beats;
            beat_q  <= '0;
            inp_q   <= start_word;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef STIM_INJECT_EN
            inj_q      <= 1'b0;
            inj_cnt_q  <= '0;
            inj_left_q <= '0;
`endif
          end
        end
        S_RUN: begin
          if (handshake) begin
            beat_q <= beat_inc;
            lfsr_q <= lfsr_d;
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
            inp_q  <= word_d;
`ifdef STIM_INJECT_EN
            inj_q      <= inj_d;
            inj_cnt_q  <= inj_cnt_d;
            inj_left_q <= inj_left_d;
`endif
            if (last_beat) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              inp_q   <= '0;
`ifdef STIM_INJECT_EN
              inj_q   <= 1'b0;
`endif
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inp        = inp_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign beat_count = beat_q;
`ifdef STIM_INJECT_EN
  assign inj_active = inj_q;
`endif

endmodule

// File: tb/tb_stim_gen_param.sv
// tb/tb_stim_gen_param.sv - directed self-checking bench for stim_gen_param
module tb_stim_gen_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // u_dut: default parameters (DATA_W=1)
  logic        start1, ready1;
  logic [1:0]  mode1;
  logic [15:0] seed1, num1, bc1;
  logic [7:0]  pat1;
  logic [0:0]  inp1;
  logic        valid1, busy1, done1;

  // u_dut4: DATA_W=4 for counter mode
  logic        start4, ready4;
  logic [1:0]  mode4;
  logic [15:0] seed4, num4, bc4;
  logic [7:0]  pat4;
  logic [3:0]  inp4;
  logic        valid4, busy4, done4;

`ifdef STIM_INJECT_EN
  logic inj1, inj4;
`endif

  stim_gen_param u_dut (
    .clk(clk), .reset(reset), .start(start1), .mode(mode1), .seed(seed1),
    .pattern(pat1), .num_beats(num1), .ready(ready1), .inp(inp1),
    .valid(valid1), .busy(busy1), .done(done1), .beat_count(bc1)
`ifdef STIM_INJECT_EN
    , .inj_active(inj1)
`endif
  );

  stim_gen_param #(.DATA_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode4), .seed(seed4),
    .pattern(pat4), .num_beats(num4), .ready(ready4), .inp(inp4),
    .valid(valid4), .busy(busy4), .done(done4), .beat_count(bc4)
`ifdef STIM_INJECT_EN
    , .inj_active(inj4)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] lfsr_exp [3] = '{16'h0001, 16'hB400, 16'h5A00};
  logic        lfsr_bit [3] = '{1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] gstep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  initial begin
    logic [15:0] s;
    int k;
    logic rseq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    start1 = 0; mode1 = 0; seed1 = 0; pat1 = 0; num1 = 0; ready1 = 1;
    start4 = 0; mode4 = 0; seed4 = 0; pat4 = 0; num4 = 0; ready4 = 1;
    step; step;
    chk("rst_inp", inp1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_beat_count", bc1, 0);
    chk("rst_lfsr", u_dut.lfsr_q, 0);
    reset = 1'b0;
    step;

    // LFSR, seed 1, three beats
    mode1 = 2'b00; seed1 = 16'h0001; num1 = 3; start1 = 1;
    step;
    start1 = 0;
    for (int i = 0; i < 3; i++) begin
      chk("lfsr_inp", inp1, lfsr_bit[i]);
      chk("lfsr_state", u_dut.lfsr_q, lfsr_exp[i]);
      chk("lfsr_valid", valid1, 1);
      chk("lfsr_done_early", done1, 0);
      step;
    end
    chk("lfsr_done", done1, 1);
    chk("lfsr_valid_drop", valid1, 0);
    chk("lfsr_busy_drop", busy1, 0);
    chk("lfsr_beat_count", bc1, 3);
    // start during DONE is lost
    start1 = 1;
    step;
    start1 = 0;
    chk("start_in_done_lost", valid1, 0);
    chk("done_one_cycle", done1, 0);
    step;
    chk("still_idle", busy1, 0);
    chk("beat_count_hold", bc1, 3);

    // Pattern mode, 16 beats
    mode1 = 2'b01; pat1 = 8'b10110010; num1 = 16; start1 = 1;
    step;
    start1 = 0;
    chk("pat_clear_bc", bc1, 0);
    for (int i = 0; i < 16; i++) begin
      chk("pat_inp", inp1, pat1[i % 8]);
      chk("pat_busy", busy1, 1);
      step;
    end
    chk("pat_done", done1, 1);
    chk("pat_beat_count", bc1, 16);
    step;
    chk("pat_busy_after", busy1, 0);
    chk("pat_done_after", done1, 0);

    // Counter mode, DATA_W=4, wraps after F
    mode4 = 2'b10; num4 = 18; start4 = 1;
    step;
    start4 = 0;
    for (int i = 0; i < 18; i++) begin
      chk("cnt_inp", inp4, i % 16);
      chk("cnt_valid", valid4, 1);
      step;
    end
    chk("cnt_done", done4, 1);
    chk("cnt_beat_count", bc4, 18);

    // Backpressure in pattern mode
    mode1 = 2'b01; pat1 = 8'b10110010; num1 = 3; start1 = 1;
    step;
    start1 = 0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      ready1 = rseq[i];
      step;
      if (rseq[i]) k++;
      chk("bp_inp", inp1, pat1[k]);
      chk("bp_valid", valid1, 1);
      chk("bp_beat_count", bc1, k);
    end
    ready1 = 0;
    step;
    chk("bp_hold_bc", bc1, 2);
    chk("bp_hold_valid", valid1, 1);
    ready1 = 1;
    step;
    chk("bp_done", done1, 1);
    chk("bp_final_bc", bc1, 3);
    step;

    // seed 0 behaves as seed 1, free-run, then reset mid-run
    mode1 = 2'b00; seed1 = 16'h0000; num1 = 0; start1 = 1;
    step;
    start1 = 0;
    s = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      chk("seed0_inp", inp1, s[0]);
      chk("seed0_state", u_dut.lfsr_q, s);
      s = gstep(s);
      step;
    end
    chk("seed0_bc5", bc1, 5);
    chk("seed0_state5", u_dut.lfsr_q, s);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", valid1, 0);
    chk("abort_busy", busy1, 0);
    chk("abort_bc", bc1, 0);
    chk("abort_lfsr", u_dut.lfsr_q, 0);
    step;
    chk("abort_no_done", done1, 0);
    reset = 1'b0;
    step;
    mode1 = 2'b01; pat1 = 8'b00000001; num1 = 2; start1 = 1;
    step;
    start1 = 0;
    chk("restart_valid", valid1, 1);
    chk("restart_inp", inp1, 1);
    step;
    chk("restart_inp2", inp1, 0);
    step;
    chk("restart_done", done1, 1);
    chk("restart_bc", bc1, 2);
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
